exec_controller: RTL

//   Sequences CPU execution in soc: produces the cpu enable strobe and replaces the free-running enable_gen.

---
 rtl/exec_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/exec_controller.sv
// exec_controller
//   Sequences CPU execution by generating the cpu_enable strobe. It supports
//   four modes: halt, single-step from a push button, slow run and turbo run.
//   A hardware breakpoint on the instruction pointer stops a run. The block
//   also keeps a saturating count of issued instructions.
//
// Ports
//   clk          in   1      system clock
//   resetn       in   1      asynchronous active-low reset
//   mode         in   2      00 halt, 01 step, 10 run slow, 11 run turbo
//   step_btn     in   1      step/resume button (synchronised level, active-high)
//   bp_en        in   1      breakpoint enable
//   bp_addr      in   IP_W   breakpoint address
//   ip           in   IP_W   current cpu instruction pointer
//   cpu_enable   out  1      registered enable strobe, one clk per instruction
//   halted       out  1      state != RUN
//   at_break     out  1      state == BREAK
//   state        out  2      0 HALT, 1 STEP, 2 RUN, 3 BREAK
//   instr_count  out  CNT_W  instructions issued, saturating at all-ones
module exec_controller #(
  parameter int unsigned SLOW_CNT = 10_000_000,
  parameter int unsigned IP_W     = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             bp_en,
  input  logic [IP_W-1:0]  bp_addr,
  input  logic [IP_W-1:0]  ip,
  output logic             cpu_enable,
  output logic             halted,
  output logic             at_break,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned TICK_W = (SLOW_CNT > 2) ? $clog2(SLOW_CNT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SLOW_CNT - 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               btn_q;
  logic               skip_q, skip_d;
  logic [1:0]         mode_q;

  logic step_edge;
  logic mode_chg;
  logic edge_ok;
  logic bp_match;
  logic pending;

  // A step edge coinciding with any mode change is discarded.
  assign step_edge = step_btn & ~btn_q;
  assign mode_chg  = (mode != mode_q);
  assign edge_ok   = step_edge & ~mode_chg;
  assign bp_match  = bp_en & (ip == bp_addr) & ~skip_q;

  always_comb begin
    state_d = state_q;
    tick_d  = '0;
    skip_d  = skip_q;
    en_d    = 1'b0;
    pending = 1'b0;

    unique case (mode)
      2'b00: begin
        state_d = ST_HALT;
        skip_d  = 1'b0;
      end
      2'b01: begin
        if (state_q == ST_STEP && edge_ok) begin
          en_d = 1'b1;
        end
        state_d = ST_STEP;
        skip_d  = 1'b0;
      end
      default: begin
        unique case (state_q)
          ST_HALT, ST_STEP: begin
            state_d = ST_RUN;
            skip_d  = 1'b0;
          end
          ST_BREAK: begin
            // Resume: execute the breakpoint instruction with the compare
            // suppressed for one issue.
            if (edge_ok) begin
              en_d    = 1'b1;
              skip_d  = 1'b1;
              state_d = ST_RUN;
            end
          end
          default: begin
            if (!mode_chg) begin
              if (mode[0]) begin
                // Turbo decides only in gap cycles so the compare always sees
                // the ip the cpu settled to after the previous enable.
                pending = ~en_q;
              end else begin
                pending = (tick_q == TICK_LAST);
                tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
              end
            end
            if (pending) begin
              skip_d = 1'b0;
              if (bp_match) begin
                state_d = ST_BREAK;
              end else begin
                en_d = 1'b1;
              end
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (en_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_HALT;
      en_q    <= 1'b0;
      tick_q  <= '0;
      cnt_q   <= '0;
      btn_q   <= 1'b1;
      skip_q  <= 1'b0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      btn_q   <= step_btn;
      skip_q  <= skip_d;
      mode_q  <= mode;
    end
  end

  assign cpu_enable  = en_q;
  assign state       = state_q;
  assign halted      = (state_q != ST_RUN);
  assign at_break    = (state_q == ST_BREAK);
  assign instr_count = cnt_q;

endmodule
